imem_stim_checker: RTL and testbench

Parametrised instruction-stream driver and register-progress checker for formal and simulation harnesses around CoreTop. It owns the core's reset sequence and serves the core's instruction-fetch port from a loadable program buffer. It can inject fetch stalls. After warm-up it checks that a selected architectural register advances by a fixed delta every time it changes, and flags any mismatch with a sticky fail.

---
 rtl/imem_stim_pkg.sv | 23 ++
 rtl/imem_stim_checker_if.sv | 20 ++
 rtl/imem_prog_buf.sv | 42 ++++
 rtl/imem_stim_checker.sv | 193 +++++++++++++++++++
 tb/tb_imem_stim_checker.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/imem_stim_pkg.sv
// Shared definitions for the instruction-stream driver / register-progress checker.
// Holds the FSM encoding and the register-file slice helper.
package imem_stim_pkg;

    localparam int STATE_W  = 3;
    localparam int XLEN_MAX = 64;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 3'd0,
        ST_CRST = 3'd1,
        ST_GAP  = 3'd2,
        ST_WARM = 3'd3,
        ST_RUN  = 3'd4
    } state_e;

    // Callers zero-pad the flat register file to XLEN_MAX lanes and truncate the result to XLEN.
    function automatic logic [XLEN_MAX-1:0] get_reg(input logic [32*XLEN_MAX-1:0] flat,
                                                    input int idx,
                                                    input int xlen);
        return flat[idx*xlen +: XLEN_MAX];
    endfunction

endpackage

// File: rtl/imem_stim_checker_if.sv
// Instruction-fetch port between the core (master) and the stimulus driver (slave).
interface imem_stim_checker_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] icache_req_addr;
    logic            icache_resp_valid;
    logic [XLEN-1:0] icache_resp_data;

    modport master (
        output icache_req_addr,
        input  icache_resp_valid,
        input  icache_resp_data
    );

    modport slave (
        input  icache_req_addr,
        output icache_resp_valid,
        output icache_resp_data
    );
endinterface

// File: rtl/imem_prog_buf.sv
// Program buffer: NUM_INST x XLEN array, one write port, one registered read port.
// Contents are deliberately not reset so a program survives a harness reset.
module imem_prog_buf #(
    parameter int XLEN     = 32,
    parameter int NUM_INST = 8,
    parameter int AW       = $clog2(NUM_INST)
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            we,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            rd_en,
    input  logic            rd_clr,
    input  logic [AW-1:0]   rd_addr,
    output logic [XLEN-1:0] rd_data
);

    logic [XLEN-1:0] mem_r [NUM_INST];
    logic [XLEN-1:0] rd_data_r;

    // Storage write port.
    always_ff @(posedge clock) begin
        if (we) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Read register: cleared when not serving, holds when a read is suppressed (stall).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_r <= '0;
        end else if (rd_clr) begin
            rd_data_r <= '0;
        end else if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/imem_stim_checker.sv
// Top: owns the core reset sequence, serves fetches from the program buffer with
// optional stall injection, and checks a register advances by a fixed delta.
module imem_stim_checker
    import imem_stim_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int NUM_INST      = 8,
    parameter int RESET_CYCLES  = 1,
    parameter int WARMUP_CYCLES = 6,
    parameter int CHK_REG       = 12,
    parameter int CHK_DELTA     = 200,
    parameter int STALL_PERIOD  = 0,
    parameter int AW            = $clog2(NUM_INST)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 prog_we,
    input  logic [AW-1:0]        prog_addr,
    input  logic [XLEN-1:0]      prog_data,
    input  logic                 start,
    output logic                 core_reset,
    imem_stim_checker_if.slave   fetch,
    input  logic [32*XLEN-1:0]   regfile,
    output logic                 check_active,
    output logic                 fail,
    output logic [15:0]          match_count,
    output logic [STATE_W-1:0]   state
);

    localparam logic [XLEN-1:0] DELTA      = XLEN'(CHK_DELTA);
    localparam logic [15:0]     RST_LAST   = 16'((RESET_CYCLES  > 1) ? RESET_CYCLES  - 1 : 0);
    localparam logic [15:0]     WARM_LAST  = 16'((WARMUP_CYCLES > 1) ? WARMUP_CYCLES - 1 : 0);
    localparam logic [15:0]     STALL_LAST = 16'((STALL_PERIOD  > 1) ? STALL_PERIOD  - 1 : 0);
    localparam bit              STALL_EN   = (STALL_PERIOD > 1);

    state_e              state_r, state_next_s;
    logic [15:0]         phase_cnt_r, phase_cnt_next_s;
    logic [15:0]         stall_cnt_r;
    logic                start_d_r;
    logic                start_rise_s;
    logic                serve_s;
    logic                stall_s;
    logic                resp_valid_r;
    logic                core_reset_r;
    logic                check_active_r;
    logic [XLEN-1:0]     shadow_r;
    logic                fail_r;
    logic [15:0]         match_count_r;
    logic [XLEN-1:0]     cur_s;
    logic [32*XLEN_MAX-1:0] regfile_pad_s;
    logic                unused_addr_s;

    assign start_rise_s = start & ~start_d_r;

    // Next-state and phase counter for the reset / warm-up sequence.
    always_comb begin
        state_next_s     = state_r;
        phase_cnt_next_s = phase_cnt_r;
        case (state_r)
            ST_IDLE: begin
                phase_cnt_next_s = 16'd0;
                if (start_rise_s) begin
                    state_next_s = ST_CRST;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CRST: begin
                if (phase_cnt_r == RST_LAST) begin
                    state_next_s     = ST_GAP;
                    phase_cnt_next_s = 16'd0;
                end else begin
                    phase_cnt_next_s = phase_cnt_r + 16'd1;
                end
            end
            ST_GAP: begin
                state_next_s     = ST_WARM;
                phase_cnt_next_s = 16'd0;
            end
            ST_WARM: begin
                if (phase_cnt_r == WARM_LAST) begin
                    state_next_s     = ST_RUN;
                    phase_cnt_next_s = 16'd0;
                end else begin
                    phase_cnt_next_s = phase_cnt_r + 16'd1;
                end
            end
            ST_RUN: begin
                state_next_s = ST_RUN;
            end
            default: begin
                state_next_s     = ST_IDLE;
                phase_cnt_next_s = 16'd0;
            end
        endcase
    end

    // Fetch serving window and stall-cycle decode.
    always_comb begin
        serve_s = (state_r == ST_WARM) || (state_r == ST_RUN);
        if (STALL_EN && serve_s && (stall_cnt_r == STALL_LAST)) begin
            stall_s = 1'b1;
        end else begin
            stall_s = 1'b0;
        end
    end

    // Monitored register, sliced out of the zero-padded flat register file.
    always_comb begin
        regfile_pad_s                = '0;
        regfile_pad_s[32*XLEN-1:0]   = regfile;
        cur_s                        = XLEN'(get_reg(regfile_pad_s, CHK_REG, XLEN));
    end

    // FSM state, phase counter, start edge detector and registered control outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= ST_IDLE;
            phase_cnt_r    <= 16'd0;
            start_d_r      <= 1'b0;
            core_reset_r   <= 1'b1;
            check_active_r <= 1'b0;
        end else begin
            state_r        <= state_next_s;
            phase_cnt_r    <= phase_cnt_next_s;
            start_d_r      <= start;
            core_reset_r   <= (state_next_s == ST_IDLE) || (state_next_s == ST_CRST);
            check_active_r <= (state_next_s == ST_RUN);
        end
    end

    // Stall counter and response-valid register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_r  <= 16'd0;
            resp_valid_r <= 1'b0;
        end else begin
            resp_valid_r <= serve_s & ~stall_s;
            if (!serve_s || stall_s) begin
                stall_cnt_r <= 16'd0;
            end else begin
                stall_cnt_r <= stall_cnt_r + 16'd1;
            end
        end
    end

    // Progress checker: any change must equal shadow + DELTA; a bad value resynchronises the shadow.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shadow_r      <= '0;
            fail_r        <= 1'b0;
            match_count_r <= 16'd0;
        end else if ((state_r == ST_WARM) && (state_next_s == ST_RUN)) begin
            shadow_r <= cur_s;
        end else if ((state_r == ST_RUN) && (cur_s != shadow_r)) begin
            shadow_r <= cur_s;
            if (cur_s == shadow_r + DELTA) begin
                if (match_count_r != 16'hFFFF) begin
                    match_count_r <= match_count_r + 16'd1;
                end
            end else begin
                fail_r <= 1'b1;
            end
        end
    end

    imem_prog_buf #(
        .XLEN     (XLEN),
        .NUM_INST (NUM_INST),
        .AW       (AW)
    ) u_prog_buf (
        .clock   (clock),
        .reset_n (reset_n),
        .we      (prog_we && (state_r == ST_IDLE)),
        .wr_addr (prog_addr),
        .wr_data (prog_data),
        .rd_en   (serve_s & ~stall_s),
        .rd_clr  (~serve_s),
        .rd_addr (fetch.icache_req_addr[AW+1:2]),
        .rd_data (fetch.icache_resp_data)
    );

    // Only the word-index bits select a slot; the rest wrap or are byte offsets.
    assign unused_addr_s = ^{fetch.icache_req_addr[XLEN-1:AW+2], fetch.icache_req_addr[1:0]};

    assign fetch.icache_resp_valid = resp_valid_r;
    assign core_reset              = core_reset_r;
    assign check_active            = check_active_r;
    assign fail                    = fail_r;
    assign match_count             = match_count_r;
    assign state                   = state_r;

endmodule

// File: tb/tb_imem_stim_checker.sv
// Directed bench: two instances (no stall / STALL_PERIOD=4) share all stimulus.
module tb_imem_stim_checker;

    logic              clock;
    logic              reset_n;
    logic              prog_we;
    logic [2:0]        prog_addr;
    logic [31:0]       prog_data;
    logic              start;
    logic [32*32-1:0]  regfile;
    logic [31:0]       req_addr;

    logic              core_reset0, core_reset1;
    logic              check_active0, check_active1;
    logic              fail0, fail1;
    logic [15:0]       match_count0, match_count1;
    logic [2:0]        state0, state1;

    int errors = 0;
    int checks = 0;

    imem_stim_checker_if #(.XLEN(32)) fetch0 ();
    imem_stim_checker_if #(.XLEN(32)) fetch1 ();

    assign fetch0.icache_req_addr = req_addr;
    assign fetch1.icache_req_addr = req_addr;

    imem_stim_checker #(.STALL_PERIOD(0)) dut0 (
        .clock        (clock),
        .reset_n      (reset_n),
        .prog_we      (prog_we),
        .prog_addr    (prog_addr),
        .prog_data    (prog_data),
        .start        (start),
        .core_reset   (core_reset0),
        .fetch        (fetch0),
        .regfile      (regfile),
        .check_active (check_active0),
        .fail         (fail0),
        .match_count  (match_count0),
        .state        (state0)
    );

    imem_stim_checker #(.STALL_PERIOD(4)) dut1 (
        .clock        (clock),
        .reset_n      (reset_n),
        .prog_we      (prog_we),
        .prog_addr    (prog_addr),
        .prog_data    (prog_data),
        .start        (start),
        .core_reset   (core_reset1),
        .fetch        (fetch1),
        .regfile      (regfile),
        .check_active (check_active1),
        .fail         (fail1),
        .match_count  (match_count1),
        .state        (state1)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_x12(input logic [31:0] v);
        regfile[12*32 +: 32] = v;
    endtask

    function automatic logic [31:0] prog_word(input int i);
        return 32'h0C86_0613 + (32'(i) << 24);
    endfunction

    initial begin
        reset_n   = 1'b0;
        prog_we   = 1'b0;
        prog_addr = 3'd0;
        prog_data = 32'd0;
        start     = 1'b0;
        regfile   = '0;
        req_addr  = 32'd0;

        #12;
        check_val("rst_state",      64'(state0),                  64'd0);
        check_val("rst_core_reset", 64'(core_reset0),             64'd1);
        check_val("rst_valid",      64'(fetch0.icache_resp_valid), 64'd0);
        check_val("rst_data",       64'(fetch0.icache_resp_data),  64'd0);
        check_val("rst_fail",       64'(fail0),                   64'd0);
        check_val("rst_match",      64'(match_count0),            64'd0);
        tick();
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            prog_we   = 1'b1;
            prog_addr = 3'(i);
            prog_data = prog_word(i);
            tick();
        end
        prog_we = 1'b0;

        start = 1'b1;
        tick();                                  // E1
        start = 1'b0;
        check_val("crst_state", 64'(state0),      64'd1);
        check_val("crst_creset", 64'(core_reset0), 64'd1);
        tick();                                  // E2
        check_val("gap_state",  64'(state0),      64'd2);
        check_val("gap_creset", 64'(core_reset0), 64'd0);
        check_val("gap_valid",  64'(fetch0.icache_resp_valid), 64'd0);
        tick();                                  // E3
        check_val("warm_state", 64'(state0), 64'd3);
        req_addr = 32'h24;
        tick();                                  // E4
        check_val("fetch_24_valid", 64'(fetch0.icache_resp_valid), 64'd1);
        check_val("fetch_24_data",  64'(fetch0.icache_resp_data),  64'(prog_word(1)));
        req_addr = 32'h27;
        tick();                                  // E5
        check_val("fetch_27_data", 64'(fetch0.icache_resp_data), 64'(prog_word(1)));
        req_addr = 32'h08;
        tick();                                  // E6
        check_val("stall_pre_valid", 64'(fetch1.icache_resp_valid), 64'd1);
        check_val("stall_pre_data",  64'(fetch1.icache_resp_data),  64'(prog_word(2)));
        req_addr = 32'h0C;
        tick();                                  // E7
        check_val("fetch_0c_data",   64'(fetch0.icache_resp_data),  64'(prog_word(3)));
        check_val("stall_valid",     64'(fetch1.icache_resp_valid), 64'd0);
        check_val("stall_hold_data", 64'(fetch1.icache_resp_data),  64'(prog_word(2)));
        req_addr = 32'h3C;
        tick();                                  // E8
        check_val("fetch_wrap_data", 64'(fetch0.icache_resp_data),  64'(prog_word(7)));
        check_val("stall_post_valid", 64'(fetch1.icache_resp_valid), 64'd1);
        check_val("warm_inactive",   64'(check_active0),            64'd0);
        tick();                                  // E9
        check_val("run_state",  64'(state0),        64'd4);
        check_val("run_active", 64'(check_active0), 64'd1);
        set_x12(32'd200);
        tick();                                  // E10
        check_val("step1_match", 64'(match_count0), 64'd1);
        check_val("step1_fail",  64'(fail0),        64'd0);
        set_x12(32'd400);
        tick();                                  // E11
        check_val("step2_match",   64'(match_count0), 64'd2);
        check_val("stall_run_fail", 64'(fail1),        64'd0);
        check_val("stall_run_match", 64'(match_count1), 64'd2);
        check_val("stall_run_valid", 64'(fetch1.icache_resp_valid), 64'd0);
        set_x12(32'd401);
        tick();                                  // E12
        check_val("bad_fail",  64'(fail0),        64'd1);
        check_val("bad_match", 64'(match_count0), 64'd2);
        set_x12(32'd601);
        tick();                                  // E13
        check_val("resync_match", 64'(match_count0), 64'd3);
        check_val("resync_fail",  64'(fail0),        64'd1);

        prog_we   = 1'b1;
        prog_addr = 3'd1;
        prog_data = 32'hDEAD_BEEF;
        start     = 1'b1;
        tick();
        prog_we = 1'b0;
        start   = 1'b0;
        tick();
        check_val("run_ignore_start", 64'(state0), 64'd4);
        req_addr = 32'h04;
        tick();
        check_val("run_buf_kept", 64'(fetch0.icache_resp_data), 64'(prog_word(1)));

        reset_n = 1'b0;
        #1;
        check_val("mid_rst_state",  64'(state0),                  64'd0);
        check_val("mid_rst_creset", 64'(core_reset0),             64'd1);
        check_val("mid_rst_fail",   64'(fail0),                   64'd0);
        check_val("mid_rst_match",  64'(match_count0),            64'd0);
        check_val("mid_rst_valid",  64'(fetch0.icache_resp_valid), 64'd0);
        check_val("mid_rst_data",   64'(fetch0.icache_resp_data),  64'd0);
        check_val("mid_rst_active", 64'(check_active0),           64'd0);
        set_x12(32'd0);
        tick();
        reset_n = 1'b1;

        start = 1'b1;
        tick();
        start = 1'b0;
        check_val("replay_crst", 64'(state0), 64'd1);
        for (int k = 0; k < 8; k++) begin
            tick();
        end
        check_val("replay_run",  64'(state0),                  64'd4);
        check_val("replay_data", 64'(fetch0.icache_resp_data),  64'(prog_word(1)));
        check_val("replay_fail", 64'(fail0),                   64'd0);
        set_x12(32'd200);
        tick();
        check_val("replay_match", 64'(match_count0), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
